// File: rtl/dec_gpr_wb_arb_pkg.sv
// Shared types for the GPR writeback arbiter: the writeback entry layout,
// the round-robin priority encoding and a GPR one-hot decode helper.
package dec_gpr_wb_arb_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    typedef struct packed {
        logic [4:0]      waddr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // Which long-latency source wins when both request in the same cycle.
    typedef enum logic {
        RR_NB  = 1'b0,
        RR_DIV = 1'b1
    } rr_pri_e;

    // One-hot decode of a GPR index, dropping x0, which is never written.
    function automatic logic [NREGS-1:1] decode_gpr(input logic [4:0] waddr);
        logic [NREGS-1:0] onehot;
        onehot        = '0;
        onehot[waddr] = 1'b1;
        return onehot[NREGS-1:1];
    endfunction

endpackage

// File: rtl/dec_gpr_wb_fifo.sv
// In-order queue of pending long-latency GPR writebacks. The head is presented
// combinationally, and a per-GPR pending vector is derived from the valid slots.
module dec_gpr_wb_fifo
    import dec_gpr_wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        push,
    input  wb_entry_t   push_entry,
    input  logic        pop,
    output logic        head_valid,
    output wb_entry_t   head,
    output logic        full,
    output logic        busy,
    output logic [30:0] pend_vec
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    logic             do_push;
    logic             do_pop;
    wb_entry_t        mem [DEPTH];

    assign full    = (count == CW'(DEPTH));
    assign busy    = (count != '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & valid[rd_ptr];

    assign head_valid = valid[rd_ptr];
    assign head       = mem[rd_ptr];

    // NOTE: payload storage has no reset; the valid bits alone define occupancy,
    // so clearing them is enough to discard every entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: every variable driven in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        valid_nxt = valid;
        if (do_pop) begin
            valid_nxt[rd_ptr] = 1'b0;
        end
        if (do_push) begin
            valid_nxt[wr_ptr] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            valid <= valid_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        pend_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pend_vec = pend_vec | decode_gpr(mem[i].waddr);
            end
        end
    end

endmodule

// File: rtl/dec_gpr_wb_arb.sv
// GPR writeback arbiter: two registered in-order pipe ports plus a third port
// draining a shared queue fed round-robin by the load-return and divider sources.
module dec_gpr_wb_arb
    import dec_gpr_wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            i0_wen,
    input  logic [4:0]      i0_waddr,
    input  logic [XLEN-1:0] i0_wd,
    input  logic            i1_wen,
    input  logic [4:0]      i1_waddr,
    input  logic [XLEN-1:0] i1_wd,
    input  logic            nb_valid,
    input  logic [4:0]      nb_waddr,
    input  logic [XLEN-1:0] nb_wd,
    output logic            nb_ready,
    input  logic            div_valid,
    input  logic [4:0]      div_waddr,
    input  logic [XLEN-1:0] div_wd,
    output logic            div_ready,
    output logic            wen0,
    output logic [4:0]      waddr0,
    output logic [XLEN-1:0] wd0,
    output logic            wen1,
    output logic [4:0]      waddr1,
    output logic [XLEN-1:0] wd1,
    output logic            wen2,
    output logic [4:0]      waddr2,
    output logic [XLEN-1:0] wd2,
    output logic [30:0]     pend_vec,
    output logic            busy
);

    rr_pri_e   pri;
    logic      live;
    logic      full;
    logic      head_valid;
    logic      conflict;
    logic      grant_nb;
    logic      grant_div;
    logic      push;
    wb_entry_t acc_entry;
    wb_entry_t head;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wen0   <= 1'b0;
            waddr0 <= '0;
            wd0    <= '0;
            wen1   <= 1'b0;
            waddr1 <= '0;
            wd1    <= '0;
        end else begin
            wen0   <= i0_wen & (i0_waddr != 5'd0);
            waddr0 <= i0_waddr;
            wd0    <= i0_wd;
            wen1   <= i1_wen & (i1_waddr != 5'd0);
            waddr1 <= i1_waddr;
            wd1    <= i1_wd;
        end
    end

    // live holds off all grants during reset and for the first cycle after it.
    assign grant_nb  = nb_valid & (~div_valid | (pri == RR_NB));
    assign grant_div = div_valid & ~grant_nb;
    assign nb_ready  = grant_nb & live & ~full;
    assign div_ready = grant_div & live & ~full;

    always_comb begin
        acc_entry = '{waddr: div_waddr, data: div_wd};
        if (nb_ready) begin
            acc_entry = '{waddr: nb_waddr, data: nb_wd};
        end
    end

    // Writes to x0 complete the handshake but never occupy a slot.
    assign push = (nb_ready | div_ready) & (acc_entry.waddr != 5'd0);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pri  <= RR_NB;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            if (nb_ready) begin
                pri <= RR_DIV;
            end else if (div_ready) begin
                pri <= RR_NB;
            end
        end
    end

    dec_gpr_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_l      (rst_l),
        .push       (push),
        .push_entry (acc_entry),
        .pop        (wen2),
        .head_valid (head_valid),
        .head       (head),
        .full       (full),
        .busy       (busy),
        .pend_vec   (pend_vec)
    );

    // The in-order pipes own the GPR this cycle; the queued write waits behind them.
    assign conflict = (wen0 & (waddr0 == head.waddr)) | (wen1 & (waddr1 == head.waddr));
    assign wen2     = head_valid & ~conflict;
    assign waddr2   = head_valid ? head.waddr : '0;
    assign wd2      = head_valid ? head.data : '0;

endmodule

// File: tb/tb_dec_gpr_wb_arb.sv
// Self-checking bench for dec_gpr_wb_arb: a per-cycle reference model with a
// scoreboard of queued writebacks, plus directed scenarios and random traffic.
module tb_dec_gpr_wb_arb;
    import dec_gpr_wb_arb_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_l;
    logic            i0_wen, i1_wen, nb_valid, div_valid;
    logic [4:0]      i0_waddr, i1_waddr, nb_waddr, div_waddr;
    logic [XLEN-1:0] i0_wd, i1_wd, nb_wd, div_wd;
    logic            nb_ready, div_ready, wen0, wen1, wen2, busy;
    logic [4:0]      waddr0, waddr1, waddr2;
    logic [XLEN-1:0] wd0, wd1, wd2;
    logic [30:0]     pend_vec;

    always #5 clk = ~clk;

    dec_gpr_wb_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l),
        .i0_wen(i0_wen), .i0_waddr(i0_waddr), .i0_wd(i0_wd),
        .i1_wen(i1_wen), .i1_waddr(i1_waddr), .i1_wd(i1_wd),
        .nb_valid(nb_valid), .nb_waddr(nb_waddr), .nb_wd(nb_wd), .nb_ready(nb_ready),
        .div_valid(div_valid), .div_waddr(div_waddr), .div_wd(div_wd), .div_ready(div_ready),
        .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
        .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
        .wen2(wen2), .waddr2(waddr2), .wd2(wd2),
        .pend_vec(pend_vec), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    wb_entry_t sb[$];
    wb_entry_t nb_q[$];
    wb_entry_t div_q[$];
    int        grant_log[$];

    logic            e_wen0, e_wen1;
    logic [4:0]      e_waddr0, e_waddr1;
    logic [XLEN-1:0] e_wd0, e_wd1;
    logic            m_live, m_pri_div;

    logic            s_wen0, s_wen2, s_nb_ready, s_div_ready, s_busy;
    logic [4:0]      s_waddr0, s_waddr2;
    logic [XLEN-1:0] s_wd0;
    logic [30:0]     s_pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        nb_valid  = 1'b0; nb_waddr  = '0; nb_wd  = '0;
        div_valid = 1'b0; div_waddr = '0; div_wd = '0;
        if (nb_q.size() != 0) begin
            nb_valid = 1'b1; nb_waddr = nb_q[0].waddr; nb_wd = nb_q[0].data;
        end
        if (div_q.size() != 0) begin
            div_valid = 1'b1; div_waddr = div_q[0].waddr; div_wd = div_q[0].data;
        end
    endtask

    // One clock: check everything at the falling edge, update the model after the rising edge.
    task automatic tick();
        logic            gn, gd, ok, conf, ew2, rst_s, acc_nb, acc_div;
        logic            c_i0, c_i1;
        logic [4:0]      c_a0, c_a1;
        logic [XLEN-1:0] c_d0, c_d1;
        logic [30:0]     exp_pend;
        @(negedge clk);
        s_wen0 = wen0; s_waddr0 = waddr0; s_wd0 = wd0;
        s_wen2 = wen2; s_waddr2 = waddr2; s_busy = busy; s_pend = pend_vec;
        s_nb_ready = nb_ready; s_div_ready = div_ready;
        if (nb_ready)  grant_log.push_back(1);
        if (div_ready) grant_log.push_back(2);

        check("wen0", 64'(wen0), 64'(e_wen0));
        if (e_wen0) begin
            check("waddr0", 64'(waddr0), 64'(e_waddr0));
            check("wd0", wd0, e_wd0);
        end
        check("wen1", 64'(wen1), 64'(e_wen1));
        if (e_wen1) begin
            check("waddr1", 64'(waddr1), 64'(e_waddr1));
            check("wd1", wd1, e_wd1);
        end

        gn = nb_valid && (!div_valid || !m_pri_div);
        gd = div_valid && !gn;
        ok = m_live && rst_l && (sb.size() < DEPTH);
        check("nb_ready", 64'(nb_ready), 64'(gn && ok));
        check("div_ready", 64'(div_ready), 64'(gd && ok));

        exp_pend = '0;
        foreach (sb[i]) exp_pend[int'(sb[i].waddr) - 1] = 1'b1;
        check("busy", 64'(busy), 64'(sb.size() != 0));
        check("pend_vec", 64'(pend_vec), 64'(exp_pend));

        ew2 = 1'b0;
        if (sb.size() != 0) begin
            conf = (e_wen0 && (e_waddr0 == sb[0].waddr)) || (e_wen1 && (e_waddr1 == sb[0].waddr));
            ew2  = !conf;
        end
        check("wen2", 64'(wen2), 64'(ew2));
        if (ew2) begin
            check("waddr2", 64'(waddr2), 64'(sb[0].waddr));
            check("wd2", wd2, sb[0].data);
            void'(sb.pop_front());
        end
        check("wen_unique", 64'((wen0 && wen1 && waddr0 == waddr1) ||
                                (wen0 && wen2 && waddr0 == waddr2) ||
                                (wen1 && wen2 && waddr1 == waddr2)), 64'(0));

        rst_s = rst_l; acc_nb = gn && ok; acc_div = gd && ok;
        c_i0 = i0_wen; c_a0 = i0_waddr; c_d0 = i0_wd;
        c_i1 = i1_wen; c_a1 = i1_waddr; c_d1 = i1_wd;

        @(posedge clk);
        #1;
        if (rst_s) begin
            if (acc_nb) begin
                if (nb_q[0].waddr != 5'd0) sb.push_back(nb_q[0]);
                void'(nb_q.pop_front());
                m_pri_div = 1'b1;
            end
            if (acc_div) begin
                if (div_q[0].waddr != 5'd0) sb.push_back(div_q[0]);
                void'(div_q.pop_front());
                m_pri_div = 1'b0;
            end
            e_wen0 = c_i0 && (c_a0 != 5'd0); e_waddr0 = c_a0; e_wd0 = c_d0;
            e_wen1 = c_i1 && (c_a1 != 5'd0); e_waddr1 = c_a1; e_wd1 = c_d1;
        end else begin
            e_wen0 = 1'b0; e_wen1 = 1'b0;
        end
        m_live = rst_s;
        drive();
    endtask

    task automatic apply_reset();
        rst_l = 1'b0;
        #1;
        check("rst_ctrl", 64'({wen0, wen1, wen2, nb_ready, div_ready, busy, pend_vec}), 64'(0));
        check("rst_addr", 64'({waddr0, waddr1, waddr2}), 64'(0));
        check("rst_wd", wd0 | wd1 | wd2, 64'(0));
        sb.delete();
        grant_log.delete();
        e_wen0 = 1'b0; e_wen1 = 1'b0; m_live = 1'b0; m_pri_div = 1'b0;
        repeat (2) tick();
        rst_l = 1'b1;
    endtask

    function automatic wb_entry_t ent(input logic [4:0] a, input logic [63:0] d);
        return '{waddr: a, data: d};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_l = 1'b0;
        i0_wen = 1'b0; i0_waddr = '0; i0_wd = '0;
        i1_wen = 1'b0; i1_waddr = '0; i1_wd = '0;

        // Both long-latency sources held from reset; pipe 0 blocks the head (GPR 10).
        nb_q.push_back(ent(5'd10, 64'hA0)); nb_q.push_back(ent(5'd12, 64'hA2));
        nb_q.push_back(ent(5'd14, 64'hA4));
        div_q.push_back(ent(5'd11, 64'hB1)); div_q.push_back(ent(5'd13, 64'hB3));
        div_q.push_back(ent(5'd15, 64'hB5));
        i0_wen = 1'b1; i0_waddr = 5'd10; i0_wd = 64'h55;
        drive();
        apply_reset();
        repeat (5) tick();
        check("rr_count", 64'(grant_log.size()), 64'(4));
        if (grant_log.size() >= 4) begin
            check("rr_g0", 64'(grant_log[0]), 64'(1));
            check("rr_g1", 64'(grant_log[1]), 64'(2));
            check("rr_g2", 64'(grant_log[2]), 64'(1));
            check("rr_g3", 64'(grant_log[3]), 64'(2));
        end
        i0_wen = 1'b0;
        tick();
        tick();
        check("full_deq_wen2", 64'(s_wen2), 64'(1));
        check("full_nb_ready", 64'(s_nb_ready), 64'(0));
        check("full_div_ready", 64'(s_div_ready), 64'(0));
        repeat (8) tick();
        check("rr_total", 64'(grant_log.size()), 64'(6));

        // Pipe ports are one-cycle registered copies; x0 writes are dropped.
        i0_wen = 1'b1; i0_waddr = 5'd5;  i0_wd = 64'hAA;
        i1_wen = 1'b1; i1_waddr = 5'd31; i1_wd = 64'h1234_5678_9ABC_DEF0;
        tick();
        i0_waddr = 5'd0; i1_wen = 1'b0;
        tick();
        check("p0_wen", 64'(s_wen0), 64'(1));
        check("p0_waddr", 64'(s_waddr0), 64'(5));
        check("p0_wd", s_wd0, 64'hAA);
        i0_wen = 1'b0;
        tick();
        check("p0_x0", 64'(s_wen0), 64'(0));

        // Head GPR 7 collides with pipe 0: held one cycle, then written.
        nb_q.push_back(ent(5'd7, 64'h77));
        i0_wen = 1'b1; i0_waddr = 5'd7; i0_wd = 64'h70;
        drive();
        tick();
        i0_wen = 1'b0;
        tick();
        check("conf_hold", 64'(s_wen2), 64'(0));
        tick();
        check("conf_release", 64'(s_wen2), 64'(1));
        check("conf_waddr2", 64'(s_waddr2), 64'(7));

        // Divider write to x0 handshakes but never queues.
        div_q.push_back(ent(5'd0, 64'h1234));
        drive();
        tick();
        check("x0_ready", 64'(s_div_ready), 64'(1));
        repeat (3) tick();
        check("x0_busy", 64'(s_busy), 64'(0));

        // Pending vector for GPR 3 and 9, then drained.
        i0_wen = 1'b1; i0_waddr = 5'd3; i1_wen = 1'b1; i1_waddr = 5'd9;
        nb_q.push_back(ent(5'd3, 64'h33)); div_q.push_back(ent(5'd9, 64'h99));
        drive();
        repeat (3) tick();
        check("pend_3_9", 64'(s_pend), 64'h104);
        i0_wen = 1'b0; i1_wen = 1'b0;
        repeat (4) tick();
        check("pend_clear", 64'(s_pend), 64'(0));
        check("pend_busy", 64'(s_busy), 64'(0));

        // Asynchronous reset with three queued entries.
        i0_wen = 1'b1; i0_waddr = 5'd20; i1_wen = 1'b1; i1_waddr = 5'd22;
        nb_q.push_back(ent(5'd20, 64'hC0)); nb_q.push_back(ent(5'd21, 64'hC1));
        div_q.push_back(ent(5'd22, 64'hC2));
        drive();
        repeat (4) tick();
        check("q3_pend", 64'(s_pend), 64'h38_0000);
        i0_wen = 1'b0; i1_wen = 1'b0;
        apply_reset();
        repeat (4) tick();

        // Random traffic against the model.
        for (int c = 0; c < 300; c++) begin
            if (nb_q.size() == 0 && $urandom_range(0, 1) == 1)
                nb_q.push_back(ent(5'($urandom_range(0, 31)), {$urandom, $urandom}));
            if (div_q.size() == 0 && $urandom_range(0, 1) == 1)
                div_q.push_back(ent(5'($urandom_range(0, 31)), {$urandom, $urandom}));
            i0_wen = 1'($urandom_range(0, 1)); i0_waddr = 5'($urandom_range(0, 31));
            i0_wd  = {$urandom, $urandom};
            i1_wen = 1'($urandom_range(0, 1)); i1_waddr = 5'($urandom_range(0, 31));
            i1_wd  = {$urandom, $urandom};
            if (i1_waddr == i0_waddr) i1_waddr = i0_waddr + 5'd1;
            drive();
            tick();
        end
        i0_wen = 1'b0; i1_wen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (sb.size() == 0 && nb_q.size() == 0 && div_q.size() == 0) break;
            tick();
        end
        check("drain_left", 64'(sb.size() + nb_q.size() + div_q.size()), 64'(0));
        tick();
        check("drain_busy", 64'(s_busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
